// File: rtl/cordic_phase_gen.sv
// Sample-rate divider and phase accumulator feeding the CORDIC core with one folded angle per tick.
// Optional LFSR dither on the truncated accumulator bits: define CORDIC_PHASE_DITHER_EN.
module cordic_phase_gen #(
  parameter int width      = 12,
  parameter int CNT        = 65536,
  parameter int freq_width = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         run,
  input  logic [freq_width-1:0]        freq,
  input  logic                         phase_clr,
  output logic signed [width-1:0]      angle,
  output logic [1:0]                   quadrant,
  output logic                         cos_neg,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  input  logic                         ovr_clr
);

  localparam int CW = $clog2(CNT);
  localparam logic [CW-1:0]    DIV_LAST = CW'(CNT - 1);
  localparam logic [width-1:0] HALF     = {1'b1, {(width-1){1'b0}}};

  typedef enum logic {S_WAIT, S_FOLD} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_div;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   w_acc_d;
  logic [width-1:0]       w_p;
  logic [1:0]             w_quad;
  logic [width-1:0]       w_angle;
  logic                   w_tick;
  logic                   w_load;
  logic signed [width-1:0] r_angle;
  logic [1:0]             r_quad;
  logic                   r_cos_neg;
  logic                   r_valid;
  logic                   r_overrun;

  assign w_tick = run && (r_div == DIV_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)        r_div <= '0;
    else if (phase_clr) r_div <= '0;
    else if (run)       r_div <= (r_div == DIV_LAST) ? '0 : r_div + CW'(1);
  end

  // Wrap-around modulo 2^ACC_WIDTH is the intended phase behaviour.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)        r_acc <= '0;
    else if (phase_clr) r_acc <= '0;
    else if (w_tick)    r_acc <= r_acc + ACC_WIDTH'(freq);
  end

`ifdef CORDIC_PHASE_DITHER_EN
  logic [15:0]          r_lfsr;
  logic [ACC_WIDTH-1:0] w_dith;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     r_lfsr <= 16'hACE1;
    else if (w_tick) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Dither only the bits that truncation throws away; its carry may reach p.
  always_comb begin
    w_dith = '0;
    for (int i = 0; i < ACC_WIDTH - width && i < 16; i++) w_dith[i] = r_lfsr[i];
  end

  assign w_acc_d = r_acc + w_dith;
`else
  assign w_acc_d = r_acc;
`endif

  assign w_p    = width'(w_acc_d >> (ACC_WIDTH - width));
  assign w_quad = w_p[width-1 -: 2];

  // p - 4Q is the same bit pattern as p modulo 2^width, so only the middle half needs work.
  always_comb begin
    w_angle = w_p;
    if (w_quad == 2'b01 || w_quad == 2'b10) w_angle = HALF - w_p;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_WAIT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:  if (w_tick) w_state_nxt = S_FOLD;
      S_FOLD:  w_state_nxt = S_WAIT;
      default: w_state_nxt = S_WAIT;
    endcase
    if (phase_clr) w_state_nxt = S_WAIT;
  end

  // A clear arriving during FOLD cancels the sample it would have produced.
  always_comb begin
    w_load = (r_state == S_FOLD) && !phase_clr;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_angle   <= '0;
      r_quad    <= '0;
      r_cos_neg <= 1'b0;
    end else if (w_load) begin
      r_angle   <= w_angle;
      r_quad    <= w_quad;
      r_cos_neg <= ^w_quad;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                     r_valid <= 1'b0;
    else if (w_load)                 r_valid <= 1'b1;
    else if (r_valid && out_ready)   r_valid <= 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                                  r_overrun <= 1'b0;
    else if (w_load && r_valid && !out_ready)     r_overrun <= 1'b1;
    else if (ovr_clr)                             r_overrun <= 1'b0;
  end

  assign angle     = r_angle;
  assign quadrant  = r_quad;
  assign cos_neg   = r_cos_neg;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;

endmodule
